fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences the instruction memory: owns the PC, issues one read per cycle
//  and absorbs the memory's 1-cycle registered read latency. Delivers
//  {pc, instruction} pairs to decode over a valid/ready handshake.
//  Handles branch/jump redirects, halt and misaligned/out-of-range faults.
//  Sits between the instruction memory and the decode stage.
// PARAMETERS
//  DWIDTH    32      data/address width
//  MEMDEPTH  1024    instruction memory depth in words; legal byte addresses are 0 .. 4*MEMDEPTH-4
//  RESET_PC  32'h0   PC loaded on reset; must be word aligned
// PORTS
//  clk              in   1       clock; all logic is posedge
//  reset            in   1       synchronous, active-high
//  imem_enable      out  1       read strobe to instruction memory
//  imem_address     out  DWIDTH  byte address; memory indexes by [31:2]
//  imem_instruction in   DWIDTH  memory data, valid the cycle after imem_enable
//  redirect_valid   in   1       one-cycle pulse: load redirect_pc and flush
//  redirect_pc      in   DWIDTH  redirect target byte address
//  halt             in   1       level: stop issuing new reads
//  instr_valid      out  1       instr_out/instr_pc are valid
//  instr_ready      in   1       decode accepts this cycle
//  instr_out        out  DWIDTH  instruction word
//  instr_pc         out  DWIDTH  byte address of instr_out
//  fault            out  1       sticky fetch fault
// BEHAVIOUR
//  Reset: pc=RESET_PC, buffer empty, pending=0, state=RUN.
//   All outputs are 0: imem_enable, instr_valid, fault, instr_out and instr_pc.
//   Any read in flight is discarded. The first issue happens in the cycle after reset deasserts.
//  Buffer: 2-entry FIFO of {pc,instr}. Its head drives instr_*, so the data is registered.
//   A transfer occurs when instr_valid && instr_ready.
//   instr_* stay stable while valid && !ready.
//  pending: set in the cycle a read is issued; the data is written into the FIFO on the next edge.
//  Issue condition (RUN state):
//   !redirect_valid && !halt && (occ + pending - pop) < 2, where pop = instr_valid & instr_ready.
//   On issue: imem_enable=1, imem_address=pc, and pc <= pc+4 (mod 2^32).
//   This sustains 1 instruction/cycle while instr_ready is held high.
//  Latency: a read issued in cycle t is captured at the end of t+1; instr_valid rises in t+2.
//  Address check:
//   Before issue, if pc >= 4*MEMDEPTH, no read is issued; state -> FAULT and fault <= 1.
//  Redirect:
//   In the redirect cycle there is no issue. The FIFO is cleared, pending data is dropped and not written, and pc <= redirect_pc.
//   A head transfer in the same cycle counts as completed.
//   Issue of redirect_pc happens at R+1; its instr_valid rises at R+3.
//   If redirect_pc[1:0] != 0: FAULT, fault <= 1, pc is unchanged.
//   Redirect has priority over halt and over the issue condition.
//  States:
//   RUN   -> HALT on halt=1; RUN -> FAULT on an address or alignment fault.
//   HALT  -> RUN when halt=0. In HALT there are no issues; pending and buffered entries still drain to decode. A redirect is accepted in HALT and updates pc.
//   FAULT: sticky until reset. No issues; FIFO flushed; instr_valid=0; redirect ignored.
//  Widths: the pc adder is DWIDTH bits and wraps silently. The range check catches wrap into illegal space.
// STRUCTURE
//  Shared package fetch_pkg holds:
//   localparams FS_RUN=2'd0, FS_HALT=2'd1, FS_FAULT=2'd2
//   INSTR_BYTES=4
//   FIFO_DEPTH=2
//  Sub-module fetch_skid_fifo: 2-entry FIFO, width 2*DWIDTH.
//   Ports push/pop/flush, plus full/empty/count.
//  The top level holds the pc register, pending flag, FSM, issue logic and range/alignment checks.
// TESTING
//  1 Stream: reset then run, ready=1 always, with mem[i]=i.
//    -> imem_address 0,4,8,... on consecutive cycles.
//    -> instr_valid from cycle 2; instr_pc=4k and instr_out=k, one per cycle.
//  2 Backpressure: ready=0 for 5 cycles mid-stream.
//    -> at most 2 reads beyond the stalled head; no drop or duplicate; order kept.
//    -> instr_* stable while stalled.
//  3 Redirect: redirect_pc=0x40 with data pending and FIFO full.
//    -> next imem_address=0x40 at R+1; instr_pc=0x40 at R+3.
//    -> no stale pc delivered after R.
//  4 Faults: redirect_pc=0x42 -> fault=1 next cycle, imem_enable stays 0.
//    pc reaching 4*MEMDEPTH (0x1000) -> fault, no issue of 0x1000.
//    Reset clears both.
//  5 Halt/reset: halt=1 for 4 cycles -> buffered items drain, no new issues; halt=0 resumes at next pc.
//    Reset asserted mid-stream -> instr_valid=0 next cycle; refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch front end: FSM encodings,
// instruction size and skid buffer geometry.
package fetch_pkg;

  localparam logic [1:0] FS_RUN   = 2'd0;
  localparam logic [1:0] FS_HALT  = 2'd1;
  localparam logic [1:0] FS_FAULT = 2'd2;

  localparam int INSTR_BYTES = 4;
  localparam int FIFO_DEPTH  = 2;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small registered FIFO holding {pc, instr} pairs between the memory return
// path and decode. Flush wins over push and pop in the same cycle.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0]    PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one read per cycle into a
// 1-cycle memory and hands {pc, instr} to decode through a 2-entry skid FIFO.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                MEMDEPTH = 1024,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_enable,
  output logic [DWIDTH-1:0] imem_address,
  input  logic [DWIDTH-1:0] imem_instruction,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr_out,
  output logic [DWIDTH-1:0] instr_pc,
  output logic              fault
);

  localparam logic [DWIDTH:0]   PC_LIMIT = (DWIDTH + 1)'(INSTR_BYTES * MEMDEPTH);
  localparam logic [DWIDTH-1:0] PC_STEP  = DWIDTH'(INSTR_BYTES);

  logic [DWIDTH-1:0] pc, pc_nxt, pend_pc;
  logic              pending;
  logic [1:0]        state, state_nxt;
  logic              fault_q;

  logic              issue, flush, raise_fault, pop, room;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    inflight;
  logic [2*DWIDTH-1:0] fifo_dout;

  assign pop      = instr_valid && instr_ready;
  // Entries that will occupy the FIFO after this edge if nothing new is issued.
  assign inflight = {1'b0, fifo_count} + (CNT_W + 1)'(pending) - (CNT_W + 1)'(pop);
  assign room     = inflight < (CNT_W + 1)'(FIFO_DEPTH);

  always_comb begin
    issue       = 1'b0;
    flush       = 1'b0;
    raise_fault = 1'b0;
    pc_nxt      = pc;
    state_nxt   = state;
    case (state)
      FS_RUN, FS_HALT: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (word_aligned(redirect_pc[1:0])) pc_nxt = redirect_pc;
          else                                raise_fault = 1'b1;
          state_nxt = halt ? FS_HALT : FS_RUN;
        end else if (state == FS_HALT) begin
          state_nxt = halt ? FS_HALT : FS_RUN;
        end else if (halt) begin
          state_nxt = FS_HALT;
        end else if ({1'b0, pc} >= PC_LIMIT) begin
          // Also catches the pc adder wrapping past the top of memory.
          raise_fault = 1'b1;
        end else if (room) begin
          issue  = 1'b1;
          pc_nxt = pc + PC_STEP;
        end
      end
      default: flush = 1'b1;
    endcase
    if (raise_fault) begin
      flush     = 1'b1;
      state_nxt = FS_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      pend_pc <= '0;
      pending <= 1'b0;
      state   <= FS_RUN;
      fault_q <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      state   <= state_nxt;
      pending <= issue;
      if (issue) pend_pc <= pc;
      if (raise_fault) fault_q <= 1'b1;
    end
  end

  fetch_skid_fifo #(.WIDTH(2 * DWIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pending && (!fifo_full || pop)),
    .pop   (pop),
    .flush (flush),
    .din   ({pend_pc, imem_instruction}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_enable  = issue && !reset;
  assign imem_address = pc;
  assign instr_valid  = !fifo_empty;
  assign instr_pc     = fifo_dout[2*DWIDTH-1:DWIDTH];
  assign instr_out    = fifo_dout[DWIDTH-1:0];
  assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a transaction-level model of outstanding fetches
// checked every cycle, plus directed literal expectations at key points.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, imem_enable, redirect_valid, halt, instr_valid, instr_ready, fault;
  logic [31:0] imem_address, imem_instruction, redirect_pc, instr_out, instr_pc;

  always #5 clk = ~clk;

  fetch_controller #(.DWIDTH(32), .MEMDEPTH(1024), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_enable(imem_enable), .imem_address(imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .fault(fault)
  );

  // Memory with mem[i] = i and one cycle of read latency.
  always @(posedge clk)
    if (imem_enable) imem_instruction <= {2'b00, imem_address[31:2]};

  int n_chk = 0, n_fail = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0b required=%0b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of reads issued but not yet delivered, each with the cycle
  // its data becomes visible to decode.
  typedef struct { logic [31:0] pc; int arr; } item_t;
  item_t       q[$];
  logic [31:0] m_pc, prev_pc, prev_out;
  bit          m_fault, m_halted, armed, prev_stall, saw_1000;
  bit          ev, pop, iss, flt_ev;
  int          cyc;

  initial begin
    armed = 0; cyc = 0; prev_stall = 0; saw_1000 = 0;
    m_pc = 0; m_fault = 0; m_halted = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        ev     = !m_fault && q.size() > 0 && q[0].arr <= cyc;
        pop    = ev && instr_ready;
        flt_ev = !reset && !m_fault && !redirect_valid && !m_halted && !halt && m_pc >= 32'h1000;
        iss    = !reset && !m_fault && !m_halted && !halt && !redirect_valid &&
                 m_pc < 32'h1000 && (q.size() - int'(pop)) < 2;
        check1("instr_valid", instr_valid, ev);
        if (ev) begin
          check32("instr_pc", instr_pc, q[0].pc);
          check32("instr_out", instr_out, q[0].pc >> 2);
        end
        check1("imem_enable", imem_enable, iss);
        if (iss) check32("imem_address", imem_address, m_pc);
        check1("fault", fault, m_fault);
        if (prev_stall && ev) begin
          check32("stall_hold_pc", instr_pc, prev_pc);
          check32("stall_hold_out", instr_out, prev_out);
        end
        if (imem_enable && imem_address == 32'h1000) saw_1000 = 1;
        prev_stall = ev && !instr_ready && !reset && !redirect_valid && !flt_ev;
        prev_pc    = instr_pc;
        prev_out   = instr_out;
        if (!reset) begin
          if (pop) void'(q.pop_front());
          if (!m_fault) begin
            if (redirect_valid) begin
              q.delete();
              if (redirect_pc[1:0] != 2'b00) m_fault = 1;
              else                           m_pc = redirect_pc;
            end else if (flt_ev) begin
              m_fault = 1;
              q.delete();
            end else if (iss) begin
              q.push_back('{m_pc, cyc + 2});
              m_pc = m_pc + 32'd4;
            end
            m_halted = halt;
          end
        end
      end
      if (reset) begin
        q.delete();
        m_pc = 0; m_fault = 0; m_halted = 0; prev_stall = 0; armed = 1;
      end
      cyc++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = 0; halt = 0; instr_ready = 1;
    repeat (3) tick;
    @(negedge clk);
    check1("rst_enable", imem_enable, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_fault", fault, 1'b0);
    check32("rst_instr_out", instr_out, 32'h0);
    check32("rst_instr_pc", instr_pc, 32'h0);

    // Stream
    tick; reset = 0;
    @(negedge clk);
    check1("first_issue_en", imem_enable, 1'b1);
    check32("first_issue_addr", imem_address, 32'h0);
    tick; tick;
    @(negedge clk);
    check1("first_valid", instr_valid, 1'b1);
    check32("first_pc", instr_pc, 32'h0);
    repeat (6) tick;

    // Backpressure
    instr_ready = 0;
    repeat (3) tick;
    @(negedge clk);
    check1("stall_no_issue", imem_enable, 1'b0);
    tick; tick;
    instr_ready = 1;
    repeat (4) tick;

    // Redirect while stalled with entries buffered
    instr_ready = 0;
    repeat (2) tick;
    redirect_valid = 1; redirect_pc = 32'h40;
    tick;
    redirect_valid = 0; instr_ready = 1;
    @(negedge clk);
    check1("redir_issue_en", imem_enable, 1'b1);
    check32("redir_issue_addr", imem_address, 32'h40);
    tick; tick;
    @(negedge clk);
    check1("redir_valid", instr_valid, 1'b1);
    check32("redir_pc", instr_pc, 32'h40);
    check32("redir_out", instr_out, 32'h10);
    repeat (5) tick;

    // Halt drains the buffer and then resumes
    halt = 1;
    repeat (3) tick;
    @(negedge clk);
    check1("halt_drained", instr_valid, 1'b0);
    check1("halt_no_issue", imem_enable, 1'b0);
    tick;
    halt = 0;
    repeat (6) tick;

    // Misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h42;
    tick;
    redirect_valid = 0;
    @(negedge clk);
    check1("misalign_fault", fault, 1'b1);
    check1("misalign_no_issue", imem_enable, 1'b0);
    repeat (3) tick;
    reset = 1;
    tick; tick;
    @(negedge clk);
    check1("reset_clears_fault", fault, 1'b0);
    tick; reset = 0;
    repeat (4) tick;

    // Run off the end of memory
    redirect_valid = 1; redirect_pc = 32'hFF0;
    tick;
    redirect_valid = 0;
    repeat (12) tick;
    @(negedge clk);
    check1("range_fault", fault, 1'b1);
    check1("no_issue_1000", saw_1000, 1'b0);
    tick; reset = 1;
    tick; tick; reset = 0;
    repeat (8) tick;

    // Reset mid-stream
    reset = 1;
    tick;
    @(negedge clk);
    check1("midrst_valid", instr_valid, 1'b0);
    tick; reset = 0;
    @(negedge clk);
    check1("midrst_refetch_en", imem_enable, 1'b1);
    check32("midrst_refetch_addr", imem_address, 32'h0);
    repeat (5) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
